alu_seq: RTL and testbench

- Multi-cycle, handshaked ALU responder: the request/response end of the 2-bit operand / 3-bit select / 5-bit result ALU interface.
- Accepts one operation per request (A, B, sel) over valid/ready.
- Computes add/sub/logic in one step, multiply by shift-add, and power by repeated multiply.
- Returns the result over a valid/ready response channel. Sits behind any initiator (bench sequencer or CPU-side control) that issues ALU operations.

---
 rtl/alu_seq.sv | 227 ++++++++++++++++++++++
 tb/tb_alu_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle handshaked ALU responder.
// Takes one (A, B, sel) request over valid/ready. Add, sub and the logic ops
// finish in one step, mul uses shift-add, and pow uses repeated multiply.
// The result is returned over a valid/ready response channel.
module alu_seq #(
    parameter int WIDTH = 2,
    parameter int OUT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_flag
);

    // Internal arithmetic width, plus headroom for a single pow multiply step
    localparam int IW = OUT_W + WIDTH;
    localparam int PW = IW + WIDTH;

    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
    localparam logic [WIDTH-1:0] MUL_LAST = WIDTH'(WIDTH - 1);
    localparam logic [IW-1:0]    ACC_ONE  = IW'(1);
    localparam logic [IW-1:0]    ACC_ZERO = IW'(0);

    generate
        if (OUT_W < WIDTH + 1) begin : g_bad_out_w
            $error("alu_seq: OUT_W must be at least WIDTH+1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [2:0]         sel_r;
    logic [IW-1:0]      acc_r;
    logic [WIDTH-1:0]   count_r;
    logic               ovf_r;
    logic               out_valid_r;
    logic [OUT_W-1:0]   out_data_r;
    logic               out_flag_r;

    logic [IW-1:0]      a_ext_s;
    logic [IW-1:0]      b_ext_s;
    logic [WIDTH-1:0]   logic_s;
    logic [WIDTH-1:0]   b_m1_s;
    logic [PW-1:0]      prod_s;
    logic [IW-1:0]      step_acc_s;
    logic [IW-1:0]      res_s;
    logic               res_flag_s;
    logic               step_last_s;

    assign a_ext_s   = IW'(a_r);
    assign b_ext_s   = IW'(b_r);
    assign b_m1_s    = b_r - ONE_W;
    assign prod_s    = PW'(acc_r) * PW'(a_r);

    assign in_ready  = (state_r == ST_IDLE);
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_flag  = out_flag_r;

    // Compute the narrow bitwise result before zero-extension so that nor stays WIDTH bits wide
    always_comb begin
        logic_s = {WIDTH{1'b0}};
        case (sel_r)
            3'd4:    logic_s = a_r & b_r;
            3'd5:    logic_s = a_r | b_r;
            3'd6:    logic_s = a_r ^ b_r;
            3'd7:    logic_s = ~(a_r | b_r);
            default: logic_s = {WIDTH{1'b0}};
        endcase
    end

    // Compute one CALC step: new accumulator, candidate result/flag, and whether this step is the last one
    always_comb begin
        step_acc_s  = acc_r;
        res_s       = ACC_ZERO;
        res_flag_s  = 1'b0;
        step_last_s = 1'b0;
        case (sel_r)
            3'd0: begin
                res_s       = a_ext_s + b_ext_s;
                res_flag_s  = |res_s[IW-1:OUT_W];
                step_last_s = 1'b1;
            end
            3'd1: begin
                res_s       = a_ext_s - b_ext_s;
                res_flag_s  = (a_r < b_r);
                step_last_s = 1'b1;
            end
            3'd2: begin
                if (b_r[count_r]) begin
                    step_acc_s = acc_r + (a_ext_s << count_r);
                end else begin
                    step_acc_s = acc_r;
                end
                res_s       = step_acc_s;
                res_flag_s  = |step_acc_s[IW-1:OUT_W];
                step_last_s = (count_r == MUL_LAST);
            end
            3'd3: begin
                if (b_r == {WIDTH{1'b0}}) begin
                    // A^0 is 1 regardless of A, in a single step
                    step_acc_s  = ACC_ONE;
                    res_s       = ACC_ONE;
                    res_flag_s  = 1'b0;
                    step_last_s = 1'b1;
                end else begin
                    // Overflow is sticky: bits lost at any intermediate step count
                    step_acc_s  = prod_s[IW-1:0];
                    res_s       = prod_s[IW-1:0];
                    res_flag_s  = ovf_r | (|prod_s[PW-1:OUT_W]);
                    step_last_s = (count_r == b_m1_s);
                end
            end
            default: begin
                res_s       = IW'(logic_s);
                res_flag_s  = 1'b0;
                step_last_s = 1'b1;
            end
        endcase
    end

    // FSM state register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_s = ST_CALC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (step_last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_CALC;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Operand capture, step accumulator and registered response outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            sel_r       <= 3'd0;
            acc_r       <= ACC_ZERO;
            count_r     <= {WIDTH{1'b0}};
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= {OUT_W{1'b0}};
            out_flag_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r     <= A;
                        b_r     <= B;
                        sel_r   <= sel;
                        acc_r   <= (sel == 3'd3) ? ACC_ONE : ACC_ZERO;
                        count_r <= {WIDTH{1'b0}};
                        ovf_r   <= 1'b0;
                    end else begin
                        count_r <= count_r;
                    end
                end
                ST_CALC: begin
                    acc_r   <= step_acc_s;
                    count_r <= count_r + ONE_W;
                    ovf_r   <= res_flag_s;
                    if (step_last_s) begin
                        out_valid_r <= 1'b1;
                        out_data_r  <= res_s[OUT_W-1:0];
                        out_flag_r  <= res_flag_s;
                    end else begin
                        out_valid_r <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors for alu_seq with a queue-based scoreboard.
// The stimulus process pushes the expected result, flag and latency of each
// request; an independent monitor pops and compares on every response handshake.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] A;
    logic [1:0] B;
    logic [2:0] sel;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_data;
    logic       out_flag;

    typedef struct {
        int   id;
        int   data;
        int   flag;
        int   lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp   = 0;
    int   n_err   = 0;
    int   cyc     = 0;
    int   acc_cyc = 0;
    int   op_id   = 0;

    alu_seq #(.WIDTH(2), .OUT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flag  (out_flag)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Edge counter used for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    // Monitor: measure latency on out_valid rise, pop and compare on handshake
    initial begin : monitor
        logic prev_v;
        int   lat_meas;
        exp_t e;
        prev_v   = 1'b0;
        lat_meas = -1;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                prev_v = 1'b0;
            end else begin
                if (out_valid && !prev_v) lat_meas = cyc - acc_cyc;
                prev_v = out_valid;
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_response: got data %0d with no pending request", out_data);
                    end else begin
                        e = sb.pop_front();
                        chk($sformatf("op%0d_data", e.id), int'(out_data), e.data);
                        chk($sformatf("op%0d_flag", e.id), int'(out_flag), e.flag);
                        chk($sformatf("op%0d_latency", e.id), lat_meas, e.lat);
                    end
                end
            end
        end
    end

    // Drive a request and return just after its accept edge; operands are then scrambled
    task automatic send(input logic [1:0] a, input logic [1:0] b, input logic [2:0] s);
        int t;
        @(posedge clk); #1;
        A = a; B = b; sel = s; in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1");
        end
        @(posedge clk); #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        A = ~a; B = ~b; sel = ~s;
    endtask

    // Wait until every expected response has been seen, then confirm the DUT is idle again
    task automatic drain(input string nm);
        int t;
        t = 0;
        while (sb.size() != 0 && t < 60) begin
            @(posedge clk); #1;
            t++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got %0d pending expected 0", nm, sb.size());
            sb.delete();
        end
        chk({nm, "_in_ready"}, int'(in_ready), 1);
    endtask

    task automatic op(input logic [1:0] a, input logic [1:0] b, input logic [2:0] s,
                      input int d, input int f, input int lat);
        exp_t e;
        op_id++;
        e.id = op_id; e.data = d; e.flag = f; e.lat = lat;
        sb.push_back(e);
        send(a, b, s);
        drain($sformatf("op%0d", op_id));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        exp_t e;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        A = 2'd0; B = 2'd0; sel = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  int'(in_ready),  1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data",  int'(out_data),  0);
        chk("rst_out_flag",  int'(out_flag),  0);
        rst_n = 1'b1;

        // add / sub
        op(2'd1, 2'd1, 3'd0,  2, 0, 1);
        op(2'd3, 2'd3, 3'd0,  6, 0, 1);
        op(2'd2, 2'd1, 3'd1,  1, 0, 1);
        op(2'd0, 2'd3, 3'd1, 29, 1, 1);
        op(2'd3, 2'd3, 3'd1,  0, 0, 1);
        op(2'd1, 2'd2, 3'd1, 31, 1, 1);
        // mul
        op(2'd3, 2'd2, 3'd2,  6, 0, 2);
        op(2'd3, 2'd3, 3'd2,  9, 0, 2);
        // pow
        op(2'd2, 2'd3, 3'd3,  8, 0, 3);
        op(2'd3, 2'd3, 3'd3, 27, 0, 3);
        op(2'd3, 2'd0, 3'd3,  1, 0, 1);
        op(2'd0, 2'd2, 3'd3,  0, 0, 2);
        // logic
        op(2'd3, 2'd1, 3'd4,  1, 0, 1);
        op(2'd2, 2'd1, 3'd5,  3, 0, 1);
        op(2'd3, 2'd1, 3'd6,  2, 0, 1);
        op(2'd2, 2'd1, 3'd7,  0, 0, 1);
        op(2'd0, 2'd0, 3'd7,  3, 0, 1);

        // Backpressure: response must hold and new requests must be refused
        out_ready = 1'b0;
        op_id++;
        e.id = op_id; e.data = 6; e.flag = 0; e.lat = 2;
        sb.push_back(e);
        send(2'd3, 2'd2, 3'd2);
        begin
            int t;
            t = 0;
            while (!out_valid && t < 20) begin
                @(posedge clk); #1;
                t++;
            end
        end
        A = 2'd1; B = 2'd1; sel = 3'd0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d_out_valid", i), int'(out_valid), 1);
            chk($sformatf("bp%0d_out_data", i),  int'(out_data),  6);
            chk($sformatf("bp%0d_in_ready", i),  int'(in_ready),  0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain("bp");

        // Reset in the middle of pow 2^3: no response may appear
        send(2'd2, 2'd3, 3'd3);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_out_data",  int'(out_data),  0);
        chk("mid_rst_in_ready",  int'(in_ready),  1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk($sformatf("post_rst%0d_out_valid", i), int'(out_valid), 0);
        end

        // Recovery after reset
        op(2'd2, 2'd2, 3'd0, 4, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
